// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding and serial CRC-8 step for the configuration-chain loader.
package cfg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, CHECK} cfg_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// cfg_crc8: serial MSB-first CRC-8 register with synchronous clear and bit enable.
module cfg_crc8
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            crc_q <= CRC8_INIT;
        else if (clr_i)
            crc_q <= CRC8_INIT;
        else if (en_i)
            crc_q <= crc8_step(crc_q, bit_i);
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: streams host words MSB-first into the switchbox config chain, then
// recirculates the chain once and compares CRCs of sent and returned bits.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_en,
    output logic              shift_en,
    output logic              cfg_data_out,
    input  logic              cfg_data_ret,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW  = $clog2(CHAIN_LEN + 1);
    localparam int CW1 = CW + 1;
    localparam int BW  = $clog2(WORD_W + 1);

    cfg_state_t        state_q;
    logic [WORD_W-1:0] hold_q;
    logic [BW-1:0]     bits_left_q;
    logic [CW-1:0]     cnt_q;
    logic              done_q;
    logic              err_q;

    logic              load;
    logic              verify;
    logic              shift;
    logic              more;
    logic              accept;
    logic              last;
    logic [CW1-1:0]    cnt_after;
    logic [CW1-1:0]    rem;
    logic [BW-1:0]     take;
    logic [7:0]        crc_tx;
    logic [7:0]        crc_rx;

    assign load   = state_q == LOAD;
    assign verify = state_q == VERIFY;
    assign shift  = load && bits_left_q != '0;
    // cnt_q counts sent bits in LOAD and returned bits in VERIFY
    assign last   = cnt_q == CW'(CHAIN_LEN - 1);
    assign more   = ({1'b0, cnt_q} + CW1'(bits_left_q)) < CW1'(CHAIN_LEN);
    assign accept = word_ready && word_valid;

    // A word arriving on the last shift of its predecessor is sized after that shift
    assign cnt_after = {1'b0, cnt_q} + CW1'(shift);
    assign rem       = CW1'(CHAIN_LEN) - cnt_after;
    assign take      = (rem >= CW1'(WORD_W)) ? BW'(WORD_W) : BW'(rem);

    assign word_ready   = load && more && bits_left_q <= BW'(1);
    assign shift_en     = shift || verify;
    assign cfg_data_out = load ? hold_q[WORD_W-1] : (verify && cfg_data_ret);
    assign cfg_en       = state_q != IDLE;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign err          = err_q;

    cfg_crc8 u_crc_tx (
        .clk   (clk),
        .nrst  (nrst),
        .clr_i (state_q == IDLE && start),
        .en_i  (shift),
        .bit_i (hold_q[WORD_W-1]),
        .crc_o (crc_tx)
    );

    cfg_crc8 u_crc_rx (
        .clk   (clk),
        .nrst  (nrst),
        .clr_i (state_q == IDLE && start),
        .en_i  (verify),
        .bit_i (cfg_data_ret),
        .crc_o (crc_rx)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            bits_left_q <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= LOAD;
                        hold_q      <= '0;
                        bits_left_q <= '0;
                        cnt_q       <= '0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        if (accept) begin
                            hold_q      <= word_in;
                            bits_left_q <= take;
                        end else if (shift) begin
                            hold_q      <= hold_q << 1;
                            bits_left_q <= bits_left_q - BW'(1);
                        end
                        if (shift) begin
                            cnt_q <= last ? '0 : cnt_q + CW'(1);
                            if (last)
                                state_q <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= last ? '0 : cnt_q + CW'(1);
                        if (last)
                            state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    done_q  <= crc_tx == crc_rx;
                    err_q   <= crc_tx != crc_rx;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed, table-driven bench for cfg_loader with ideal and faulty
// serial chain models (16-bit and 12-bit chains).
module tb_cfg_loader;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, abort = 1'b0, word_valid = 1'b0;
    logic [7:0] word_in = '0;
    logic       word_ready, cfg_en, shift_en, cfg_data_out, cfg_data_ret, busy, done, err;

    cfg_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .cfg_en(cfg_en), .shift_en(shift_en), .cfg_data_out(cfg_data_out),
        .cfg_data_ret(cfg_data_ret), .busy(busy), .done(done), .err(err)
    );

    logic       s12_start = 1'b0, s12_valid = 1'b0;
    logic [7:0] s12_word = '0;
    logic       s12_ready, s12_cfg_en, s12_shift, s12_out, s12_ret, s12_busy, s12_done, s12_err;

    cfg_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
        .clk(clk), .nrst(nrst), .start(s12_start), .abort(1'b0),
        .word_in(s12_word), .word_valid(s12_valid), .word_ready(s12_ready),
        .cfg_en(s12_cfg_en), .shift_en(s12_shift), .cfg_data_out(s12_out),
        .cfg_data_ret(s12_ret), .busy(s12_busy), .done(s12_done), .err(s12_err)
    );

    // Chain models; the 16-bit one can corrupt the returned bit at verify index 5
    logic [15:0] chain = '0;
    logic [7:0]  scnt = '0;
    logic        flip_en = 1'b0;
    logic [11:0] chain12 = '0;

    always @(posedge clk) begin
        if (start && !busy)
            scnt <= '0;
        else if (shift_en) begin
            chain <= {chain[14:0], cfg_data_out};
            scnt  <= scnt + 8'd1;
        end
        if (s12_shift)
            chain12 <= {chain12[10:0], s12_out};
    end

    assign cfg_data_ret = chain[15] ^ (flip_en && scnt == 8'd21);
    assign s12_ret      = chain12[11];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          gap;
        bit          flip;
        int          abort_at;
        logic [15:0] stream;
        int          acc;
        int          stalls;
        int          endc;
        bit          done;
        bit          err;
    } vec_t;

    vec_t v[7];

    // Drives one load on the 16-bit loader; cycle 1 is the first LOAD cycle
    task automatic run(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                       input bit flp, input int abort_at, input int rst_at,
                       output logic [15:0] stream, output int acc, output int stalls,
                       output int fs, output int endc);
        logic [7:0] words [3];
        int idx, gc, nb;
        words[0] = w0; words[1] = w1; words[2] = 8'hFF;
        stream = '0; acc = 0; stalls = 0; fs = -1; endc = -1;
        idx = 0; gc = 0; nb = 0;
        flip_en = flp;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (!busy) begin
                endc = c;
                break;
            end
            if (rst_at >= 0 && nb >= 16 + rst_at) begin
                nrst = 1'b0;
                #1;
                break;
            end
            if (abort_at >= 0 && nb == abort_at)
                abort = 1'b1;
            else if (shift_en) begin
                if (fs < 0) fs = c;
                if (nb < 16) stream = {stream[14:0], cfg_data_out};
                nb++;
            end else if (nb > 0 && nb < 16)
                stalls++;
            word_valid = idx < 3 && gc == 0;
            word_in    = idx < 3 ? words[idx] : 8'h00;
            if (word_ready && word_valid) begin
                acc++;
                idx++;
                if (idx == 1) gc = gap;
            end else if (word_ready && gc > 0)
                gc--;
        end
        abort = 1'b0;
        word_valid = 1'b0;
    endtask

    logic [15:0] stream;
    int acc, stalls, fs, endc;
    logic [11:0] stream12;
    int acc12, late12, nb12, endc12, idx12;
    logic [7:0] w12 [3];

    initial begin
        v[0] = '{8'hA5, 8'h3C, 0, 1'b0, -1, 16'hA53C, 2, 0, 35, 1'b1, 1'b0};
        v[1] = '{8'hA5, 8'h3C, 3, 1'b0, -1, 16'hA53C, 2, 3, 38, 1'b1, 1'b0};
        v[2] = '{8'hA5, 8'h3C, 0, 1'b1, -1, 16'hA53C, 2, 0, 35, 1'b0, 1'b1};
        v[3] = '{8'h00, 8'hFF, 0, 1'b0, -1, 16'h00FF, 2, 0, 35, 1'b1, 1'b0};
        v[4] = '{8'hA5, 8'h3C, 0, 1'b0,  5, 16'h0014, 1, 0,  8, 1'b0, 1'b1};
        v[5] = '{8'hA5, 8'h3C, 0, 1'b0, 15, 16'h529E, 2, 0, 18, 1'b0, 1'b1};
        v[6] = '{8'h5A, 8'hC3, 1, 1'b0, -1, 16'h5AC3, 2, 1, 36, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {word_ready, cfg_en, shift_en, cfg_data_out, busy, done, err}, 7'b0);
        chk("reset_outputs12", {s12_ready, s12_cfg_en, s12_shift, s12_out, s12_busy, s12_done, s12_err}, 7'b0);
        nrst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(v[i].w0, v[i].w1, v[i].gap, v[i].flip, v[i].abort_at, -1, stream, acc, stalls, fs, endc);
            chk($sformatf("row%0d_stream", i), stream, v[i].stream);
            chk($sformatf("row%0d_accepted", i), acc, v[i].acc);
            chk($sformatf("row%0d_stalls", i), stalls, v[i].stalls);
            chk($sformatf("row%0d_first_shift", i), fs, 2);
            chk($sformatf("row%0d_end_cycle", i), endc, v[i].endc);
            chk($sformatf("row%0d_done", i), done, v[i].done);
            chk($sformatf("row%0d_err", i), err, v[i].err);
            chk($sformatf("row%0d_idle_outs", i), {cfg_en, shift_en, word_ready, cfg_data_out}, 4'b0);
            if (!v[i].flip && v[i].abort_at < 0)
                chk($sformatf("row%0d_chain", i), chain, v[i].stream);
        end

        run(8'hA5, 8'h3C, 0, 1'b0, -1, 5, stream, acc, stalls, fs, endc);
        chk("nrst_mid_verify", {word_ready, cfg_en, shift_en, cfg_data_out, busy, done, err}, 7'b0);
        @(negedge clk);
        nrst = 1'b1;
        run(8'hA5, 8'h3C, 0, 1'b0, -1, -1, stream, acc, stalls, fs, endc);
        chk("after_rst_stream", stream, 16'hA53C);
        chk("after_rst_end_cycle", endc, 35);
        chk("after_rst_done", {done, err}, 2'b10);

        w12[0] = 8'hFF; w12[1] = 8'h0F; w12[2] = 8'hAA;
        stream12 = '0; acc12 = 0; late12 = 0; nb12 = 0; endc12 = -1; idx12 = 0;
        @(negedge clk);
        s12_start = 1'b1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            s12_start = 1'b0;
            if (!s12_busy) begin
                endc12 = c;
                break;
            end
            if (s12_shift) begin
                if (nb12 < 12) stream12 = {stream12[10:0], s12_out};
                nb12++;
            end
            s12_valid = idx12 < 3;
            s12_word  = idx12 < 3 ? w12[idx12] : 8'h00;
            if (acc12 == 2 && s12_ready) late12++;
            if (s12_ready && s12_valid) begin
                acc12++;
                idx12++;
            end
        end
        s12_valid = 1'b0;
        chk("len12_stream", stream12, 12'hFF0);
        chk("len12_accepted", acc12, 2);
        chk("len12_late_ready", late12, 0);
        chk("len12_shifts", nb12, 24);
        chk("len12_end_cycle", endc12, 27);
        chk("len12_done_err", {s12_done, s12_err}, 2'b10);
        chk("len12_chain", chain12, 12'hFF0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
